// File: rtl/if_id_pkg.sv
// Shared definitions for the IF/ID stall responder: FSM encoding, per-cycle
// action encoding and the fixed pipeline constants.
package if_id_pkg;

  // FSM encoding; the numeric values are visible on the fsm_state debug port.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Exactly one action is taken per cycle, chosen by fixed priority.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_STALL   = 2'd1,
    ACT_ERROR   = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_t;

  // Bubble instruction: addi x0,x0,0.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  // Sequential fetch step in bytes.
  localparam int unsigned PC_INC = 4;

  // Resolve the action for this cycle: FLUSH > ERROR > STALL > ADVANCE.
  function automatic action_t decode_action(input logic branch_taken,
                                            input logic pc_write,
                                            input logic if_id_write);
    if (branch_taken) begin
      return ACT_FLUSH;
    end else if (pc_write && !if_id_write) begin
      return ACT_ERROR;
    end else if (!pc_write) begin
      return ACT_STALL;
    end else begin
      return ACT_ADVANCE;
    end
  endfunction

endpackage

// File: rtl/if_id_stall_responder_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, stick at the maximum value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/if_id_stall_responder.sv
// Consumer end of the load-use hazard interface. Owns the PC and the IF/ID
// pipeline register, obeys the hazard unit's write enables and bubble select,
// applies EX-stage branch flushes, and keeps stall/flush statistics plus two
// sticky health flags (illegal handshake, over-long stall).
//
// Hazard handshake semantics (sampled every rising edge, acted on next cycle):
//   PC_Write=1, IF_ID_REG_Write=1 : normal fetch advance.
//   PC_Write=0                    : PC frozen; IF/ID frozen only when
//                                   IF_ID_REG_Write=0, otherwise reloaded.
//   PC_Write=1, IF_ID_REG_Write=0 : illegal (would drop an instruction);
//                                   treated as a full hold and flagged.
//   branch_taken=1                : overrides all of the above.
// control_MUX_select is registered into ID_EXE_bubble on every non-flush
// cycle; a flush always forces the bubble.
module if_id_stall_responder
  import if_id_pkg::*;
#(
  parameter int unsigned        XLEN      = 32,
  parameter int unsigned        ILEN      = 32,
  parameter logic [XLEN-1:0]    RESET_PC  = '0,
  parameter logic [ILEN-1:0]    NOP_INSTR = ILEN'(NOP_INSTR_DEFAULT),
  parameter int unsigned        MAX_STALL = 4,
  parameter int unsigned        CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PC_Write,
  input  logic             IF_ID_REG_Write,
  input  logic             control_MUX_select,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [ILEN-1:0]  imem_instr,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  IF_ID_pc,
  output logic [ILEN-1:0]  IF_ID_instr,
  output logic             IF_ID_valid,
  output logic             ID_EXE_bubble,
  output logic [1:0]       fsm_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             protocol_err,
  output logic             stall_timeout
);

  // Run counter only needs to reach MAX_STALL+1; it holds there afterwards.
  localparam int unsigned RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  target_aligned;
  logic [RUN_W-1:0] stall_run;
  logic [RUN_W-1:0] stall_run_next;
  state_t           state;
  action_t          action;

  assign imem_addr = pc;
  assign fsm_state = state;

  // Branch targets are forced to a word boundary.
  assign target_aligned = branch_target & ~XLEN'(3);

  // Pick the single action for this cycle and the next stall run length.
  always_comb begin
    action         = decode_action(branch_taken, PC_Write, IF_ID_REG_Write);
    stall_run_next = '0;
    if (action == ACT_STALL) begin
      stall_run_next = (stall_run == RUN_LIMIT) ? stall_run : stall_run + RUN_W'(1);
    end
  end

  // PC, IF/ID register, bubble request, FSM state and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      IF_ID_pc      <= '0;
      IF_ID_instr   <= NOP_INSTR;
      IF_ID_valid   <= 1'b0;
      ID_EXE_bubble <= 1'b0;
      state         <= ST_RUN;
      stall_run     <= '0;
      protocol_err  <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      stall_run <= stall_run_next;
      if (stall_run_next == RUN_LIMIT) begin
        stall_timeout <= 1'b1;
      end
      unique case (action)
        ACT_FLUSH: begin
          pc            <= target_aligned;
          IF_ID_instr   <= NOP_INSTR;
          IF_ID_valid   <= 1'b0;
          ID_EXE_bubble <= 1'b1;
          state         <= ST_FLUSH;
        end
        ACT_ERROR: begin
          protocol_err  <= 1'b1;
          ID_EXE_bubble <= control_MUX_select;
          state         <= ST_STALL;
        end
        ACT_STALL: begin
          if (IF_ID_REG_Write) begin
            IF_ID_pc    <= pc;
            IF_ID_instr <= imem_instr;
            IF_ID_valid <= 1'b1;
          end
          ID_EXE_bubble <= control_MUX_select;
          state         <= ST_STALL;
        end
        default: begin
          IF_ID_pc      <= pc;
          IF_ID_instr   <= imem_instr;
          IF_ID_valid   <= 1'b1;
          pc            <= pc + XLEN'(PC_INC);
          ID_EXE_bubble <= control_MUX_select;
          state         <= ST_RUN;
        end
      endcase
    end
  end

  // Saturating count of stall cycles (ERROR holds are not counted).
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (action == ACT_STALL),
    .count (stall_count)
  );

  // Saturating count of branch flushes.
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (action == ACT_FLUSH),
    .count (flush_count)
  );

endmodule

// File: tb/tb_if_id_stall_responder.sv
// Directed bench for if_id_stall_responder: a table of per-cycle input
// records with hand-computed expected outputs, followed by hand-written
// sequences for async reset mid-stall and counter saturation.
module tb_if_id_stall_responder;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0]      addr;
    logic [31:0]      ifpc;
    logic [31:0]      instr;
    logic             valid;
    logic             bub;
    logic [1:0]       st;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
    logic             pe;
    logic             to;
  } out_t;

  typedef struct {
    logic        pw;
    logic        iw;
    logic        mux;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] imem;
    out_t        exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             PC_Write, IF_ID_REG_Write, control_MUX_select, branch_taken;
  logic [31:0]      branch_target, imem_instr;
  logic [31:0]      imem_addr, IF_ID_pc, IF_ID_instr;
  logic             IF_ID_valid, ID_EXE_bubble, protocol_err, stall_timeout;
  logic [1:0]       fsm_state;
  logic [CNT_W-1:0] stall_count, flush_count;

  if_id_stall_responder #(
    .XLEN(32), .ILEN(32), .RESET_PC(32'h0000_0100), .NOP_INSTR(32'h0000_0013),
    .MAX_STALL(4), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .PC_Write(PC_Write), .IF_ID_REG_Write(IF_ID_REG_Write),
    .control_MUX_select(control_MUX_select),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_instr(imem_instr), .imem_addr(imem_addr),
    .IF_ID_pc(IF_ID_pc), .IF_ID_instr(IF_ID_instr), .IF_ID_valid(IF_ID_valid),
    .ID_EXE_bubble(ID_EXE_bubble), .fsm_state(fsm_state),
    .stall_count(stall_count), .flush_count(flush_count),
    .protocol_err(protocol_err), .stall_timeout(stall_timeout)
  );

  out_t act;
  assign act = {imem_addr, IF_ID_pc, IF_ID_instr, IF_ID_valid, ID_EXE_bubble,
                fsm_state, stall_count, flush_count, protocol_err, stall_timeout};

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[20];

  function automatic out_t mk(input logic [31:0] addr, input logic [31:0] ifpc,
                              input logic [31:0] instr, input logic v, input logic b,
                              input logic [1:0] st, input int sc, input int fc,
                              input logic pe, input logic to);
    out_t o;
    o = {addr, ifpc, instr, v, b, st, CNT_W'(sc), CNT_W'(fc), pe, to};
    return o;
  endfunction

  function automatic vec_t mv(input logic pw, input logic iw, input logic mux,
                              input logic br, input logic [31:0] tgt,
                              input logic [31:0] imem, input out_t exp);
    vec_t v;
    v.pw = pw; v.iw = iw; v.mux = mux; v.br = br;
    v.tgt = tgt; v.imem = imem; v.exp = exp;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: set inputs, let one rising edge pass, sample 1 time unit later
  task automatic apply(input logic pw, input logic iw, input logic mux,
                       input logic br, input logic [31:0] tgt, input logic [31:0] imem);
    PC_Write = pw; IF_ID_REG_Write = iw; control_MUX_select = mux;
    branch_taken = br; branch_target = tgt; imem_instr = imem;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // RUN=0 STALL=1 FLUSH=2
    vecs[0]  = mv(1,1,0,0,0,32'hA, mk(32'h104,32'h100,32'hA,1,0,0,0,0,0,0));
    vecs[1]  = mv(1,1,0,0,0,32'hB, mk(32'h108,32'h104,32'hB,1,0,0,0,0,0,0));
    vecs[2]  = mv(1,1,0,0,0,32'hC, mk(32'h10C,32'h108,32'hC,1,0,0,0,0,0,0));
    vecs[3]  = mv(0,0,1,0,0,32'hD, mk(32'h10C,32'h108,32'hC,1,1,1,1,0,0,0));
    vecs[4]  = mv(1,1,0,0,0,32'hD, mk(32'h110,32'h10C,32'hD,1,0,0,1,0,0,0));
    vecs[5]  = mv(0,0,1,0,0,32'hE, mk(32'h110,32'h10C,32'hD,1,1,1,2,0,0,0));
    vecs[6]  = mv(0,0,1,1,32'h203,32'hE, mk(32'h200,32'h10C,32'h13,0,1,2,2,1,0,0));
    vecs[7]  = mv(1,1,0,0,0,32'h11, mk(32'h204,32'h200,32'h11,1,0,0,2,1,0,0));
    vecs[8]  = mv(1,0,1,0,0,32'h22, mk(32'h204,32'h200,32'h11,1,1,1,2,1,1,0));
    vecs[9]  = mv(1,1,0,0,0,32'h22, mk(32'h208,32'h204,32'h22,1,0,0,2,1,1,0));
    vecs[10] = mv(0,1,0,0,0,32'h33, mk(32'h208,32'h208,32'h33,1,0,1,3,1,1,0));
    vecs[11] = mv(1,1,0,1,32'hFFFF_FFFE,32'h0, mk(32'hFFFF_FFFC,32'h208,32'h13,0,1,2,3,2,1,0));
    vecs[12] = mv(1,0,0,1,32'hFFFF_FFFF,32'h0, mk(32'hFFFF_FFFC,32'h208,32'h13,0,1,2,3,3,1,0));
    vecs[13] = mv(1,1,0,0,0,32'h44, mk(32'h0,32'hFFFF_FFFC,32'h44,1,0,0,3,3,1,0));
    for (int k = 0; k < 5; k++) begin
      vecs[14+k] = mv(0,0,0,0,0,32'h55,
                      mk(32'h0,32'hFFFF_FFFC,32'h44,1,0,1,4+k,3,1,(k == 4)));
    end
    vecs[19] = mv(1,1,0,0,0,32'h66, mk(32'h4,32'h0,32'h66,1,0,0,8,3,1,1));

    PC_Write = 1'b1; IF_ID_REG_Write = 1'b1; control_MUX_select = 1'b0;
    branch_taken = 1'b0; branch_target = '0; imem_instr = '0;

    // reset state
    #12;
    check("reset", mk(32'h100,32'h0,32'h13,0,0,0,0,0,0,0));
    rst_n = 1'b1;

    // table
    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].pw, vecs[i].iw, vecs[i].mux, vecs[i].br, vecs[i].tgt, vecs[i].imem);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // async reset in the middle of a stall
    apply(0,0,1,0,0,32'h77);
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_stall", mk(32'h100,32'h0,32'h13,0,0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(0,0,0,0,0,32'h77);
    check("first_stall_after_reset", mk(32'h100,32'h0,32'h13,0,0,1,1,0,0,0));

    // stall count saturates at 15, timeout set
    for (int k = 0; k < 19; k++) apply(0,0,0,0,0,32'h77);
    check("stall_saturate", mk(32'h100,32'h0,32'h13,0,0,1,15,0,0,1));

    // flush count saturates at 15 with repeated branches
    for (int k = 0; k < 17; k++) apply(1,1,0,1,32'h301,32'h77);
    check("flush_saturate", mk(32'h300,32'h0,32'h13,0,1,2,15,15,0,1));

    apply(1,1,0,0,0,32'h77);
    check("advance_after_flush", mk(32'h304,32'h300,32'h77,1,0,0,15,15,0,1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
